prog_mem_loader: RTL and testbench
==================================

// Module: prog_mem_loader
// PURPOSE
//  Host-side writer for the microprocessor's 16x8 program memory; the CPU fetch path reads it.
//  Accepts a nibble stream on DataIn, assembles 8-bit instruction words, and writes them from address 0.
//  Each instruction word is opcode in the high nibble, operand in the low nibble.
//  Verifies an 8-bit checksum, then releases CpuHold so the CPU starts fetching.
// PARAMETERS
//  ADDR_W      4   program memory address width (depth = 2**ADDR_W)
//  WORD_W      8   instruction width = opcode nibble + operand nibble
//  MAX_OPCODE  5   highest legal opcode (NOP0 ADD1 SUB2 OUT3 IN4 LOAD5)
// PORTS
//  MainClock    in   1       single clock, all state updates on rising edge
//  MainClear    in   1       synchronous, active-high reset
//  LoadStart    in   1       one-cycle pulse: begin a load session
//  DataIn       in   4       host nibble
//  NibbleValid  in   1       DataIn valid this cycle
//  NibbleReady  out  1       loader accepts DataIn this cycle
//  MemWrEn      out  1       one-cycle program-memory write strobe
//  MemWrAddr    out  ADDR_W  write address
//  MemWrData    out  WORD_W  write data {opcode, operand}
//  CpuHold      out  1       1 = CPU held in clear (drive CPU clear)
//  LoadDone     out  1       level: last session loaded and verified
//  LoadErr      out  1       level: last session failed (checksum or opcode)
// BEHAVIOUR
//  Reset (MainClear=1 at edge): state IDLE; NibbleReady=0, MemWrEn=0, MemWrAddr=0, MemWrData=0,
//   CpuHold=1, LoadDone=0, LoadErr=0, sum=0, count=0, OpBad=0. Reset mid-session aborts with no further writes.
//  Handshake: a nibble is taken on an edge with NibbleValid&NibbleReady; no buffering; DataIn ignored otherwise.
//  States:
//   IDLE/DONE/ERR -- LoadStart=1: ->LEN, clear sum/addr/OpBad/LoadDone/LoadErr, CpuHold=1.
//   LEN    -- Ready=1; accept nibble N, N+1 words to follow (1..16); ->HI.
//   HI     -- Ready=1; accept opcode nibble; if > MAX_OPCODE set sticky OpBad; ->LO.
//   LO     -- Ready=1; accept operand nibble; ->WR.
//   WR     -- Ready=0; MemWrEn=1 exactly this cycle with addr/data; sum+=word (mod 256).
//             addr==N: ->CKH; else addr++ and ->HI.
//   CKH    -- Ready=1; accept checksum high nibble.
//   CKL    -- Ready=1; accept checksum low nibble; compare with sum.
//             Match and !OpBad: ->DONE. Otherwise: ->ERR.
//   DONE   -- LoadDone=1, CpuHold=0 (from cycle after transition).
//   ERR    -- LoadErr=1, CpuHold stays 1; memory contents left as written.
//  Latency: last operand nibble accepted -> MemWrEn next cycle; checksum low accepted -> Done/Err next cycle.
//  Throughput: one word per 3 cycles when NibbleValid held high.
//  LoadStart while in LEN..CKL is ignored; LoadStart in DONE re-asserts CpuHold the next cycle.
//  LoadStart and MainClear in the same cycle: reset wins.
//  MemWrAddr never wraps: N=15 writes addresses 0..15, then the session ends.
//  Checksum is an 8-bit modular sum of all written words; carries are discarded.
// STRUCTURE
//  Shared package loader_pkg:
//   - state enum (IDLE LEN HI LO WR CKH CKL DONE ERR)
//   - opcode constants OP_NOP..OP_LOAD, also used by the CPU decoder
//  Sub-module prog_chk_accum: 8-bit modular accumulator with clear/add/compare; the rest is inline.
// TESTING
//  1 Reset with stream active -> all outputs at reset values, CpuHold=1, no MemWrEn.
//  2 Start, N=2, words 0x41,0x1A,0x33, checksum 0x8E ->
//     writes @0=41, @1=1A, @2=33; LoadDone=1, CpuHold=0.
//  3 Same stream with checksum 0x8F -> LoadErr=1, LoadDone=0, CpuHold=1, three writes done.
//  4 Word 0x7F (opcode 7 > 5) with a correct checksum -> word written; LoadErr=1 at end.
//  5 N=15 with NibbleValid toggled randomly -> 16 writes at 0..15, no wrap, correct Done.
//  6 LoadStart mid-HI -> ignored; MainClear mid-WR -> IDLE, no further writes,
//     then a new LoadStart loads cleanly.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the program-memory loader and the CPU decoder:
// loader state encoding and the instruction opcode set.
package loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN,
    ST_HI,
    ST_LO,
    ST_WR,
    ST_CKH,
    ST_CKL,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_OUT  = 4'd3;
  localparam logic [3:0] OP_IN   = 4'd4;
  localparam logic [3:0] OP_LOAD = 4'd5;

endpackage

// File: rtl/prog_chk_accum.sv
// Modular running sum of written instruction words; carries out of the top bit
// are dropped, and match compares the sum against a received checksum.
module prog_chk_accum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         add,
  input  logic [W-1:0] data,
  input  logic [W-1:0] ref_val,
  output logic         match
);

  logic [W-1:0] sum;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + data;
    end
  end

  assign match = (sum == ref_val);

endmodule

// File: rtl/prog_mem_loader.sv
// Host-side loader: assembles a nibble stream into instruction words, writes
// them to program memory from address 0, verifies a checksum and frees the CPU.
module prog_mem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int WORD_W     = 8,
  parameter int MAX_OPCODE = 5
) (
  input  logic              MainClock,
  input  logic              MainClear,
  input  logic              LoadStart,
  input  logic [3:0]        DataIn,
  input  logic              NibbleValid,
  output logic              NibbleReady,
  output logic              MemWrEn,
  output logic [ADDR_W-1:0] MemWrAddr,
  output logic [WORD_W-1:0] MemWrData,
  output logic              CpuHold,
  output logic              LoadDone,
  output logic              LoadErr
);

  localparam int                NIB_W  = WORD_W / 2;
  localparam logic [NIB_W-1:0]  MAX_OP = NIB_W'(MAX_OPCODE);

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] last_addr;
  logic [NIB_W-1:0]  opcode;
  logic [NIB_W-1:0]  operand;
  logic [NIB_W-1:0]  ck_hi;
  logic              op_bad;
  logic              take;
  logic              start_ok;
  logic              ck_match;

  assign take     = NibbleValid & NibbleReady;
  assign start_ok = LoadStart && (state inside {ST_IDLE, ST_DONE, ST_ERR});

  always_ff @(posedge MainClock) begin
    if (MainClear) state <= ST_IDLE;
    else           state <= next_state;
  end

  // NOTE: next_state is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (LoadStart) next_state = ST_LEN;
      ST_LEN:  if (take) next_state = ST_HI;
      ST_HI:   if (take) next_state = ST_LO;
      ST_LO:   if (take) next_state = ST_WR;
      ST_WR:   next_state = (addr == last_addr) ? ST_CKH : ST_HI;
      ST_CKH:  if (take) next_state = ST_CKL;
      ST_CKL:  if (take) next_state = (ck_match && !op_bad) ? ST_DONE : ST_ERR;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge MainClock) begin
    if (MainClear) begin
      addr      <= '0;
      last_addr <= '0;
      opcode    <= '0;
      operand   <= '0;
      ck_hi     <= '0;
      op_bad    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (LoadStart) begin
            addr   <= '0;
            op_bad <= 1'b0;
          end
        end
        ST_LEN: if (take) last_addr <= ADDR_W'(DataIn);
        ST_HI: begin
          if (take) begin
            opcode <= DataIn;
            if (DataIn > MAX_OP) op_bad <= 1'b1;
          end
        end
        ST_LO:  if (take) operand <= DataIn;
        // The address stops at the last word rather than wrapping.
        ST_WR:  if (addr != last_addr) addr <= addr + ADDR_W'(1);
        ST_CKH: if (take) ck_hi <= DataIn;
        default: ;
      endcase
    end
  end

  prog_chk_accum #(.W(WORD_W)) u_chk (
    .clk     (MainClock),
    .rst     (MainClear),
    .clr     (start_ok),
    .add     (state == ST_WR),
    .data    ({opcode, operand}),
    .ref_val ({ck_hi, DataIn}),
    .match   (ck_match)
  );

  assign NibbleReady = state inside {ST_LEN, ST_HI, ST_LO, ST_CKH, ST_CKL};
  assign MemWrEn     = (state == ST_WR);
  assign MemWrAddr   = addr;
  assign MemWrData   = {opcode, operand};
  assign CpuHold     = (state != ST_DONE);
  assign LoadDone    = (state == ST_DONE);
  assign LoadErr     = (state == ST_ERR);

endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader: the driver queues expected writes and
// session outcomes from a sum-of-words model; a monitor checks what appears.
module tb_prog_mem_loader;

  logic       MainClock = 1'b0;
  logic       MainClear;
  logic       LoadStart;
  logic [3:0] DataIn;
  logic       NibbleValid;
  logic       NibbleReady;
  logic       MemWrEn;
  logic [3:0] MemWrAddr;
  logic [7:0] MemWrData;
  logic       CpuHold;
  logic       LoadDone;
  logic       LoadErr;

  prog_mem_loader dut (
    .MainClock   (MainClock),
    .MainClear   (MainClear),
    .LoadStart   (LoadStart),
    .DataIn      (DataIn),
    .NibbleValid (NibbleValid),
    .NibbleReady (NibbleReady),
    .MemWrEn     (MemWrEn),
    .MemWrAddr   (MemWrAddr),
    .MemWrData   (MemWrData),
    .CpuHold     (CpuHold),
    .LoadDone    (LoadDone),
    .LoadErr     (LoadErr)
  );

  always #5 MainClock = ~MainClock;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wr_q[$];
  logic [1:0] res_q[$];   // {done, err}
  logic [7:0] prog[16];
  int         vectors = 0;
  int         miscompares = 0;
  logic       prev_outcome = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe and every new session outcome is matched
  // against the oldest queued expectation.
  always @(negedge MainClock) begin
    if (MemWrEn === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", {MemWrAddr, MemWrData}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        check("wr_addr", MemWrAddr, e.a);
        check("wr_data", MemWrData, e.d);
      end
    end
    if ((LoadDone | LoadErr) && !prev_outcome) begin
      if (res_q.size() == 0) begin
        check("unexpected_outcome", {LoadDone, LoadErr}, 2'b00);
      end else begin
        logic [1:0] r;
        r = res_q.pop_front();
        check("outcome", {LoadDone, LoadErr, CpuHold}, {r, ~r[1]});
      end
    end
    prev_outcome <= LoadDone | LoadErr;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, NibbleReady, 0);
    check({tag, "_wren"},  MemWrEn, 0);
    check({tag, "_addr"},  MemWrAddr, 0);
    check({tag, "_data"},  MemWrData, 0);
    check({tag, "_hold"},  CpuHold, 1);
    check({tag, "_done"},  LoadDone, 0);
    check({tag, "_err"},   LoadErr, 0);
  endtask

  // Called and returns at a negedge; the nibble is taken on the posedge in between.
  task automatic send_nibble(input logic [3:0] d, input bit gaps);
    int budget = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        NibbleValid = 1'b0;
        DataIn = 4'($urandom);
        @(negedge MainClock);
      end
    end
    NibbleValid = 1'b1;
    DataIn = d;
    while (NibbleReady !== 1'b1 && budget < 50) begin
      @(negedge MainClock);
      budget++;
    end
    if (NibbleReady !== 1'b1) check("ready_timeout", 0, 1);
    @(negedge MainClock);
    NibbleValid = 1'b0;
    DataIn = 4'($urandom);
  endtask

  // One session of words prog[0..n]; ck_xor corrupts the transmitted checksum.
  task automatic load(input logic [3:0] n, input logic [7:0] ck_xor,
                      input bit gaps, input bit poke);
    logic [7:0] sum = 8'h00;
    logic [7:0] ck;
    bit         bad = 1'b0;
    LoadStart = 1'b1;
    @(negedge MainClock);
    LoadStart = 1'b0;
    check("start_hold", {CpuHold, LoadDone, LoadErr}, 3'b100);
    for (int i = 0; i <= int'(n); i++) begin
      sum = sum + prog[i];
      if (prog[i][7:4] > 4'd5) bad = 1'b1;
      wr_q.push_back('{a: 4'(i), d: prog[i]});
    end
    ck = sum ^ ck_xor;
    res_q.push_back((!bad && ck == sum) ? 2'b10 : 2'b01);
    send_nibble(n, gaps);
    if (poke) begin
      LoadStart = 1'b1;
      @(negedge MainClock);
      LoadStart = 1'b0;
    end
    for (int i = 0; i <= int'(n); i++) begin
      send_nibble(prog[i][7:4], gaps);
      send_nibble(prog[i][3:0], gaps);
    end
    send_nibble(ck[7:4], gaps);
    send_nibble(ck[3:0], gaps);
    check("outcome_latency", LoadDone | LoadErr, 1);
    check("writes_drained", wr_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    MainClear = 1'b1;
    LoadStart = 1'b1;
    NibbleValid = 1'b1;
    DataIn = 4'h3;
    repeat (4) begin
      @(negedge MainClock);
      DataIn = 4'($urandom);
    end
    check_reset_outputs("reset");
    MainClear = 1'b0;
    LoadStart = 1'b0;
    repeat (3) begin
      @(negedge MainClock);
      DataIn = 4'($urandom);
    end
    check_reset_outputs("idle_stream");
    NibbleValid = 1'b0;

    // Directed: good checksum, bad checksum, illegal opcode.
    prog[0] = 8'h41; prog[1] = 8'h1A; prog[2] = 8'h33;
    load(4'd2, 8'h00, 1'b0, 1'b0);
    load(4'd2, 8'h01, 1'b0, 1'b0);
    prog[0] = 8'h7F; prog[1] = 8'h12;
    load(4'd1, 8'h00, 1'b0, 1'b0);

    // Full-depth session with a bursty stream.
    for (int i = 0; i < 16; i++) prog[i] = {4'($urandom_range(0, 5)), 4'($urandom)};
    load(4'd15, 8'h00, 1'b1, 1'b0);
    check("full_last_addr", MemWrAddr, 4'd15);

    // LoadStart while mid-session is ignored.
    for (int i = 0; i < 3; i++) prog[i] = {4'($urandom_range(0, 5)), 4'($urandom)};
    load(4'd2, 8'h00, 1'b0, 1'b1);

    // Reset while the second word is being written: nothing after it.
    prog[0] = 8'h25; prog[1] = 8'h53;
    LoadStart = 1'b1;
    @(negedge MainClock);
    LoadStart = 1'b0;
    wr_q.push_back('{a: 4'd0, d: prog[0]});
    wr_q.push_back('{a: 4'd1, d: prog[1]});
    send_nibble(4'd3, 1'b0);
    send_nibble(prog[0][7:4], 1'b0);
    send_nibble(prog[0][3:0], 1'b0);
    send_nibble(prog[1][7:4], 1'b0);
    send_nibble(prog[1][3:0], 1'b0);
    check("abort_in_wr", MemWrEn, 1);
    MainClear = 1'b1;
    NibbleValid = 1'b1;
    @(negedge MainClock);
    MainClear = 1'b0;
    repeat (4) begin
      DataIn = 4'($urandom);
      @(negedge MainClock);
    end
    check_reset_outputs("abort");
    NibbleValid = 1'b0;
    for (int i = 0; i < 5; i++) prog[i] = {4'($urandom_range(0, 5)), 4'($urandom)};
    load(4'd4, 8'h00, 1'b0, 1'b0);

    // Randomized sessions: any opcode, occasional checksum corruption.
    for (int s = 0; s < 8; s++) begin
      logic [3:0] n;
      logic [7:0] cx;
      n = 4'($urandom);
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 3) == 0 ? $urandom : {$urandom_range(0, 5), 4'($urandom)});
      cx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      load(n, cx, 1'($urandom), 1'b0);
    end

    repeat (4) @(negedge MainClock);
    check("wr_queue_empty", wr_q.size(), 0);
    check("res_queue_empty", res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
